// File: rtl/mc_controller.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback
// and produces the ALU function code. Optional MC_CTRL_ILLEGAL_TRAP_EN
// sends unknown instructions to a HALT state instead of treating them as NOPs.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [2:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [3:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JUMP    = 4'd11,
        HALT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BLEZ = 6'b000110;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    // Destination for unrecognised op/funct codes
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    localparam state_t BAD_ST = HALT;
`else
    localparam state_t BAD_ST = FETCH;
`endif

    state_t cur;
    state_t nxt;

    logic       fok;
    logic [3:0] fctl;

    logic pcen_s;
    logic irwrite_s;
    logic memwrite_s;
    logic regwrite_s;

    // R-type funct to ALU code; fok flags a known funct
    always_comb begin
        fok  = 1'b1;
        fctl = 4'b0000;
        case (funct)
            6'b100000: fctl = 4'b0010;
            6'b100010: fctl = 4'b0110;
            6'b100100: fctl = 4'b0000;
            6'b100101: fctl = 4'b0001;
            6'b101010: fctl = 4'b0111;
            6'b100110: fctl = 4'b1001;
            6'b000000: fctl = 4'b0011;
            6'b000010: fctl = 4'b1100;
            6'b000110: fctl = 4'b1011;
            default:   fok  = 1'b0;
        endcase
    end

    // Next-state selection, including memory stalls and op dispatch
    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:   nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW:       nxt = MEMADR;
                    OP_RT:              nxt = RTYPEEX;
                    OP_BEQ, OP_BLEZ:    nxt = BRANCH;
                    OP_ADDI, OP_ORI,
                    OP_XORI, OP_LUI:    nxt = IMMEX;
                    OP_J:               nxt = JUMP;
                    default:            nxt = BAD_ST;
                endcase
            end
            MEMADR: begin
                if (op == OP_SW)
                    nxt = MEMWR;
                else if (op == OP_LW)
                    nxt = MEMRD;
                else
                    nxt = FETCH;
            end
            MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
            MEMWB:   nxt = FETCH;
            MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
            RTYPEEX: nxt = fok ? ALUWB : BAD_ST;
            ALUWB:   nxt = FETCH;
            BRANCH:  nxt = FETCH;
            IMMEX:   nxt = IMMWB;
            IMMWB:   nxt = FETCH;
            JUMP:    nxt = FETCH;
            HALT:    nxt = BAD_ST;
            default: nxt = FETCH;
        endcase
    end

    // State register; reset drops straight back to FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cur <= FETCH;
        else
            cur <= nxt;
    end

    // Moore output decode with the handshake-gated strobes
    always_comb begin
        pcen_s     = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 3'b000;
        pcsrc      = 2'b00;
        alucontrol = 4'b0000;
        illegal    = 1'b0;
        case (cur)
            FETCH: begin
                alusrcb    = 3'b001;
                alucontrol = 4'b0010;
                pcen_s     = mem_ready;
                irwrite_s  = mem_ready;
            end
            DECODE: begin
                alusrcb    = 3'b011;
                alucontrol = 4'b0010;
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 3'b010;
                alucontrol = 4'b0010;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = fctl;
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                pcsrc   = 2'b01;
                pcen_s  = zero;
                if (op == OP_BEQ)
                    alucontrol = 4'b0110;
                else if (op == OP_BLEZ)
                    alucontrol = 4'b1010;
            end
            IMMEX: begin
                alusrca = 1'b1;
                case (op)
                    OP_ADDI: begin
                        alusrcb    = 3'b010;
                        alucontrol = 4'b0010;
                    end
                    OP_ORI: begin
                        alusrcb    = 3'b100;
                        alucontrol = 4'b0001;
                    end
                    OP_XORI: begin
                        alusrcb    = 3'b100;
                        alucontrol = 4'b1001;
                    end
                    OP_LUI: begin
                        alusrcb    = 3'b100;
                        alucontrol = 4'b1000;
                    end
                    default: ;
                endcase
            end
            IMMWB: regwrite_s = 1'b1;
            JUMP: begin
                pcsrc  = 2'b10;
                pcen_s = 1'b1;
            end
            HALT: illegal = 1'b1;
            default: ;
        endcase
    end

    // Write strobes are suppressed the instant reset asserts
    assign pcen     = pcen_s & reset;
    assign irwrite  = irwrite_s & reset;
    assign memwrite = memwrite_s & reset;
    assign regwrite = regwrite_s & reset;
    assign state    = cur;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: each step drives inputs, queues the
// expected output vector, then pops and checks it mid-cycle.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] alucontrol;
    logic       illegal;
    logic [3:0] state;

    int tests;
    int fails;

    logic [21:0] sb[$];

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BLEZ = 6'b000110;
    localparam logic [5:0] LUI  = 6'b001111;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;
    localparam logic [5:0] SRL  = 6'b000010;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcen       (pcen),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stb = {pcen,irwrite,memwrite,regwrite}
    // sel = {regdst,memtoreg,iord,alusrca}
    task automatic step(
        input string      tag,
        input logic       rs,
        input logic [5:0] o,
        input logic [5:0] f,
        input logic       z,
        input logic       m,
        input logic [3:0] st,
        input logic [3:0] stb,
        input logic [3:0] sel,
        input logic [2:0] b,
        input logic [1:0] pc,
        input logic [3:0] alu,
        input logic       il
    );
        logic [21:0] obs;
        logic [21:0] exp;
        @(negedge clk);
        reset     = rs;
        op        = o;
        funct     = f;
        zero      = z;
        mem_ready = m;
        sb.push_back({st, stb, sel, b, pc, alu, il});
        #2;
        obs = {state, pcen, irwrite, memwrite, regwrite,
               regdst, memtoreg, iord, alusrca,
               alusrcb, pcsrc, alucontrol, illegal};
        exp = sb.pop_front();
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b0;
        op        = LW;
        funct     = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;

        step("rst_fetch", 0, LW, 0, 0, 1, 0, 4'b0000, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);
        step("lw_fetch",  1, LW, 0, 0, 1, 0, 4'b1100, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);
        step("lw_decode", 1, LW, 0, 0, 1, 1, 4'b0000, 4'b0000, 3'b011, 2'b00, 4'b0010, 0);
        step("lw_memadr", 1, LW, 0, 0, 1, 2, 4'b0000, 4'b0001, 3'b010, 2'b00, 4'b0010, 0);
        step("lw_memrd",  1, LW, 0, 0, 1, 3, 4'b0000, 4'b0010, 3'b000, 2'b00, 4'b0000, 0);
        step("lw_memwb",  1, LW, 0, 0, 1, 4, 4'b0001, 4'b0100, 3'b000, 2'b00, 4'b0000, 0);

        step("sw_fstall", 1, SW, 0, 0, 0, 0, 4'b0000, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);
        step("sw_fetch",  1, SW, 0, 0, 1, 0, 4'b1100, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);
        step("sw_decode", 1, SW, 0, 0, 1, 1, 4'b0000, 4'b0000, 3'b011, 2'b00, 4'b0010, 0);
        step("sw_memadr", 1, SW, 0, 0, 1, 2, 4'b0000, 4'b0001, 3'b010, 2'b00, 4'b0010, 0);
        step("sw_memwr0", 1, SW, 0, 0, 0, 5, 4'b0010, 4'b0010, 3'b000, 2'b00, 4'b0000, 0);
        step("sw_memwr1", 1, SW, 0, 0, 0, 5, 4'b0010, 4'b0010, 3'b000, 2'b00, 4'b0000, 0);
        step("sw_memwr2", 1, SW, 0, 0, 1, 5, 4'b0010, 4'b0010, 3'b000, 2'b00, 4'b0000, 0);

        step("rt_fetch",  1, RT, SRL, 0, 1, 0, 4'b1100, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);
        step("rt_decode", 1, RT, SRL, 0, 1, 1, 4'b0000, 4'b0000, 3'b011, 2'b00, 4'b0010, 0);
        step("rt_ex_srl", 1, RT, SRL, 0, 1, 6, 4'b0000, 4'b0001, 3'b000, 2'b00, 4'b1100, 0);
        step("rt_aluwb",  1, RT, SRL, 0, 1, 7, 4'b0001, 4'b1000, 3'b000, 2'b00, 4'b0000, 0);

        step("beq_fetch", 1, BEQ, 0, 1, 1, 0, 4'b1100, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);
        step("beq_dec",   1, BEQ, 0, 1, 1, 1, 4'b0000, 4'b0000, 3'b011, 2'b00, 4'b0010, 0);
        step("beq_taken", 1, BEQ, 0, 1, 1, 8, 4'b1000, 4'b0001, 3'b000, 2'b01, 4'b0110, 0);
        step("beq_fetch2",1, BEQ, 0, 0, 1, 0, 4'b1100, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);
        step("beq_dec2",  1, BEQ, 0, 0, 1, 1, 4'b0000, 4'b0000, 3'b011, 2'b00, 4'b0010, 0);
        step("beq_ntkn",  1, BEQ, 0, 0, 1, 8, 4'b0000, 4'b0001, 3'b000, 2'b01, 4'b0110, 0);

        step("blez_fetch",1, BLEZ, 0, 0, 1, 0, 4'b1100, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);
        step("blez_dec",  1, BLEZ, 0, 0, 1, 1, 4'b0000, 4'b0000, 3'b011, 2'b00, 4'b0010, 0);
        step("blez_br",   1, BLEZ, 0, 0, 1, 8, 4'b0000, 4'b0001, 3'b000, 2'b01, 4'b1010, 0);

        step("lui_fetch", 1, LUI, 0, 0, 1, 0, 4'b1100, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);
        step("lui_dec",   1, LUI, 0, 0, 1, 1, 4'b0000, 4'b0000, 3'b011, 2'b00, 4'b0010, 0);
        step("lui_immex", 1, LUI, 0, 0, 1, 9, 4'b0000, 4'b0001, 3'b100, 2'b00, 4'b1000, 0);
        step("lui_immwb", 1, LUI, 0, 0, 1, 10, 4'b0001, 4'b0000, 3'b000, 2'b00, 4'b0000, 0);

        step("j_fetch",   1, JMP, 0, 0, 1, 0, 4'b1100, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);
        step("j_dec",     1, JMP, 0, 0, 1, 1, 4'b0000, 4'b0000, 3'b011, 2'b00, 4'b0010, 0);
        step("j_jump",    1, JMP, 0, 0, 1, 11, 4'b1000, 4'b0000, 3'b000, 2'b10, 4'b0000, 0);

        step("bad_fetch", 1, BAD, 0, 0, 1, 0, 4'b1100, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);
        step("bad_dec",   1, BAD, 0, 0, 1, 1, 4'b0000, 4'b0000, 3'b011, 2'b00, 4'b0010, 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        step("bad_halt",  1, BAD, 0, 0, 1, 12, 4'b0000, 4'b0000, 3'b000, 2'b00, 4'b0000, 1);
        step("bad_hold",  1, LW,  0, 1, 1, 12, 4'b0000, 4'b0000, 3'b000, 2'b00, 4'b0000, 1);
        step("halt_rst",  0, LW,  0, 0, 1, 0, 4'b0000, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);
        step("halt_rel",  1, LW,  0, 0, 1, 0, 4'b1100, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);
        step("halt_dec",  1, SW,  0, 0, 1, 1, 4'b0000, 4'b0000, 3'b011, 2'b00, 4'b0010, 0);
        step("halt_madr", 1, SW,  0, 0, 1, 2, 4'b0000, 4'b0001, 3'b010, 2'b00, 4'b0010, 0);
`else
        step("bad_nop",   1, SW,  0, 0, 0, 0, 4'b0000, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);
        step("nop_fetch", 1, SW,  0, 0, 1, 0, 4'b1100, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);
        step("nop_dec",   1, SW,  0, 0, 1, 1, 4'b0000, 4'b0000, 3'b011, 2'b00, 4'b0010, 0);
        step("nop_madr",  1, SW,  0, 0, 1, 2, 4'b0000, 4'b0001, 3'b010, 2'b00, 4'b0010, 0);
`endif
        step("rs_memwr",  1, SW, 0, 0, 0, 5, 4'b0010, 4'b0010, 3'b000, 2'b00, 4'b0000, 0);
        step("rs_abort",  0, SW, 0, 0, 0, 0, 4'b0000, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);
        step("rs_hold",   0, SW, 0, 0, 1, 0, 4'b0000, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);
        step("rs_rel",    1, SW, 0, 0, 1, 0, 4'b1100, 4'b0000, 3'b001, 2'b00, 4'b0010, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control FSM that drives the datapath around the ALU, including its 4-bit function code, one state per clock. It decodes `op`/`funct` from the instruction register, sequences fetch, decode, execute, memory and writeback, and stalls on a memory ready handshake. It is the producer of the `f` code the ALU consumes, so its encodings match the ALU's exactly.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low.
- `op` in 6: instruction opcode from the instruction register.
- `funct` in 6: R-type function field.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pcen` out 1: PC write enable.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `memwrite` out 1: memory write strobe.
- `irwrite` out 1: instruction register load.
- `regdst` out 1: 1 = rd, 0 = rt.
- `memtoreg` out 1: 1 = memory data, 0 = ALUOut.
- `regwrite` out 1: register file write.
- `alusrca` out 1: 0 = PC, 1 = register A.
- `alusrcb` out 3: B operand select.
  - 000 = register B.
  - 001 = 4.
  - 010 = sign-extended immediate.
  - 011 = sign-extended immediate << 2.
  - 100 = zero-extended immediate.
- `pcsrc` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrol` out 4: ALU function code.
- `illegal` out 1: unknown instruction flag.
- `state` out 4: current state, for debug.

## Operation
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3.
  - MEMWB 4, MEMWR 5, RTYPEEX 6, ALUWB 7.
  - BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11, HALT 12.
- Outputs are Moore-decoded from `state`; exceptions are the gated strobes listed below. Any output not listed for a state is 0.
- FETCH
  - Drives iord=0, alusrca=0, alusrcb=001, alucontrol=0010, pcsrc=00.
  - irwrite = pcen = mem_ready.
  - Holds while mem_ready=0; moves to DECODE on mem_ready=1.
- DECODE
  - Drives alusrca=0, alusrcb=011, alucontrol=0010 to precompute the branch target.
  - Next state by op:
    - lw 100011 or sw 101011 -> MEMADR.
    - R-type 000000 -> RTYPEEX.
    - beq 000100 or blez 000110 -> BRANCH.
    - addi 001000, ori 001101, xori 001110, lui 001111 -> IMMEX.
    - j 000010 -> JUMP.
    - Any other op -> see Configuration.
- MEMADR
  - Drives alusrca=1, alusrcb=010, alucontrol=0010.
  - lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1; holds until mem_ready, then -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1; -> FETCH.
- MEMWR
  - iord=1, memwrite=1, held until mem_ready=1.
  - Goes to FETCH in the cycle mem_ready=1.
- RTYPEEX
  - Drives alusrca=1, alusrcb=000; -> ALUWB.
  - alucontrol by funct:
    - 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001.
    - 101010 -> 0111, 100110 -> 1001.
    - 000000 -> 0011, 000010 -> 1100, 000110 -> 1011.
    - Any other funct is illegal; it is treated like an unknown op.
- ALUWB: regdst=1, memtoreg=0, regwrite=1; -> FETCH.
- BRANCH
  - Drives alusrca=1, alusrcb=000, pcsrc=01.
  - alucontrol: beq = 0110, blez = 1010.
  - pcen = zero; -> FETCH.
- IMMEX
  - Drives alusrca=1.
  - addi: alusrcb=010, alucontrol=0010.
  - ori: alusrcb=100, alucontrol=0001.
  - xori: alusrcb=100, alucontrol=1001.
  - lui: alusrcb=100, alucontrol=1000.
  - -> IMMWB.
- IMMWB: regdst=0, memtoreg=0, regwrite=1; -> FETCH.
- JUMP: pcsrc=10, pcen=1; -> FETCH.
- `op`/`funct` are sampled as presented. The datapath holds the IR stable from DECODE until the next FETCH.

## Timing
- Reset asserted (low)
  - state = FETCH immediately.
  - pcen, irwrite, memwrite and regwrite are forced to 0 regardless of mem_ready.
  - illegal = 0.
  - Remaining outputs take their FETCH values: iord 0, alusrca 0, alusrcb 001, alucontrol 0010, pcsrc 00, regdst 0, memtoreg 0.
- Reset mid-instruction aborts it. No write strobe is issued after reset asserts.
- Cycle counts with zero-wait memory (mem_ready=1):
  - lw 5.
  - sw, R-type and immediate ops 4.
  - beq, blez and j 3.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in all other states.
- State updates on the rising clk edge only.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined:
  - An unknown op in DECODE, or an unknown funct in RTYPEEX, goes to HALT.
  - In HALT all strobes are 0 and illegal=1 until reset.
- Not defined:
  - Unknown op/funct returns to FETCH next cycle as a NOP, with no strobes.
  - illegal stays 0 and HALT is unreachable.

## Test plan
- Release reset with mem_ready=1, op=lw -> states 0,1,2,3,4,0. regwrite=1 only in MEMWB; pcen=1 only in FETCH.
- sw with mem_ready low for 2 cycles in MEMWR -> memwrite=1 for 3 cycles; FETCH reached the cycle after mem_ready rises.
- R-type funct 000010 (srl) -> alucontrol=1100 in RTYPEEX; regdst=1 and regwrite=1 in ALUWB.
- beq with zero=1, then with zero=0 -> pcen=1 with pcsrc=01, then pcen=0. blez shows alucontrol=1010.
- lui -> IMMEX shows alusrcb=100, alucontrol=1000; IMMWB shows regwrite=1, regdst=0.
- op=111111, each build:
  - With the macro: HALT, illegal=1, stays there; reset low returns to FETCH with illegal=0.
  - Without the macro: FETCH next cycle, no strobes.
- Reset pulsed in MEMWR -> memwrite drops to 0 immediately and state=0.
